// File: rtl/gps_ca_code_gen_pkg.sv
// Shared constants and types for the GPS L1 C/A code generator:
// code length, G1/G2 feedback masks, per-PRN G2 phase-selector taps, FSM states.
package gps_code_pkg;

    localparam int CA_CODE_LEN = 1023;

    typedef logic [9:0] chip_idx_t;
    typedef logic [5:0] prn_t;

    localparam chip_idx_t CHIP_IDX_LAST = chip_idx_t'(CA_CODE_LEN - 1);

    // Register stages are numbered 10..1; stage 10 is the output, feedback enters stage 1.
    localparam logic [10:1] G1_TAP_MASK = 10'h204;  // stages 3,10
    localparam logic [10:1] G2_TAP_MASK = 10'h3A6;  // stages 2,3,6,8,9,10
    localparam logic [10:1] LFSR_INIT   = 10'h3FF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // G2 stages xored together to produce the delayed G2 for one satellite.
    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
    } g2_taps_t;

    localparam g2_taps_t G2_TAP_TABLE [32] = '{
        '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
        '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
        '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
        '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
        '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
        '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
        '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
        '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9}
    };

    function automatic logic prn_valid(input prn_t prn);
        return (prn >= 6'd1) && (prn <= 6'd32);
    endfunction

    // Caller guarantees prn is in 1..32.
    function automatic g2_taps_t prn_taps(input prn_t prn);
        prn_t offs;
        offs = prn - 6'd1;
        return G2_TAP_TABLE[offs[4:0]];
    endfunction

endpackage

// File: rtl/gps_ca_code_gen_if.sv
// Control inputs and code outputs of the C/A code generator.
interface gps_ca_code_gen_if;
    import gps_code_pkg::*;

    logic      nco_msb;
    logic      start;
    logic      stop;
    prn_t      prn_sel;
    logic      code_chip;
    chip_idx_t chip_idx;
    logic      epoch;
    logic      bit_edge;
    logic      busy;
    logic      prn_err;

    modport master (
        output nco_msb, start, stop, prn_sel,
        input  code_chip, chip_idx, epoch, bit_edge, busy, prn_err
    );

    modport slave (
        input  nco_msb, start, stop, prn_sel,
        output code_chip, chip_idx, epoch, bit_edge, busy, prn_err
    );

endinterface

// File: rtl/gps_ca_code_gen_lfsr.sv
// 10-stage Fibonacci LFSR: stage 10 is the output, parity of the tapped
// stages is fed back into stage 1. load has priority over shift.
module gps_lfsr10
    import gps_code_pkg::*;
#(
    parameter logic [10:1] TAP_MASK = G1_TAP_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    output logic [10:1] q
);

    // Shift register: reload to all-ones or advance one chip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_INIT;
        end else if (load) begin
            q <= LFSR_INIT;
        end else if (shift) begin
            q <= {q[9:1], ^(q & TAP_MASK)};
        end
    end

endmodule

// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A Gold-code generator. Advances one chip per rising edge of the
// code NCO MSB, tracks chip index, and emits 1 ms epoch / nav-bit-edge strobes.
module gps_ca_code_gen
    import gps_code_pkg::*;
#(
    parameter int EPOCHS_PER_BIT = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    gps_ca_code_gen_if.slave      bus
);

    localparam int EPOCH_CNT_W = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam logic [EPOCH_CNT_W-1:0] EPOCH_CNT_LAST = EPOCH_CNT_W'(EPOCHS_PER_BIT - 1);

    state_t                 state_reg, state_next;
    logic                   msb_d_reg;
    logic                   tick_r_reg;
    chip_idx_t              chip_idx_reg;
    logic [EPOCH_CNT_W-1:0] epoch_cnt_reg;
    g2_taps_t               taps_reg;
    logic                   epoch_reg;
    logic                   bit_edge_reg;
    logic                   prn_err_reg;

    logic        run;
    logic        start_ok;
    logic        start_bad;
    logic        adv;
    logic        wrap;
    logic        lfsr_load;
    logic        lfsr_shift;
    logic [10:1] g1_q;
    logic [10:1] g2_q;

    // Control decode: stop outranks start, a valid start outranks a pending tick.
    always_comb begin
        run        = (state_reg == RUN);
        start_ok   = bus.start & ~bus.stop & prn_valid(bus.prn_sel);
        start_bad  = bus.start & ~bus.stop & ~prn_valid(bus.prn_sel);
        wrap       = (chip_idx_reg == CHIP_IDX_LAST);
        adv        = run & tick_r_reg & ~bus.stop & ~start_ok;
        lfsr_load  = start_ok | (adv & wrap);
        lfsr_shift = adv & ~wrap;
    end

    // Rising-edge detect on the NCO MSB; a held-high MSB yields one tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_d_reg  <= 1'b0;
            tick_r_reg <= 1'b0;
        end else begin
            msb_d_reg  <= bus.nco_msb;
            tick_r_reg <= bus.nco_msb & ~msb_d_reg;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_ok) state_next = RUN;
            RUN:  if (bus.stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Chip/epoch counters, tap latch and one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chip_idx_reg  <= '0;
            epoch_cnt_reg <= '0;
            taps_reg      <= prn_taps(6'd1);
            epoch_reg     <= 1'b0;
            bit_edge_reg  <= 1'b0;
            prn_err_reg   <= 1'b0;
        end else begin
            epoch_reg    <= 1'b0;
            bit_edge_reg <= 1'b0;
            prn_err_reg  <= start_bad;
            if (bus.stop) begin
                chip_idx_reg  <= '0;
                epoch_cnt_reg <= '0;
            end else if (start_ok) begin
                taps_reg      <= prn_taps(bus.prn_sel);
                chip_idx_reg  <= '0;
                epoch_cnt_reg <= '0;
            end else if (adv) begin
                if (wrap) begin
                    chip_idx_reg <= '0;
                    epoch_reg    <= 1'b1;
                    if (epoch_cnt_reg == EPOCH_CNT_LAST) begin
                        epoch_cnt_reg <= '0;
                        bit_edge_reg  <= 1'b1;
                    end else begin
                        epoch_cnt_reg <= epoch_cnt_reg + 1'b1;
                    end
                end else begin
                    chip_idx_reg <= chip_idx_reg + 1'b1;
                end
            end
        end
    end

    gps_lfsr10 #(.TAP_MASK(G1_TAP_MASK)) u_g1 (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .q     (g1_q)
    );

    gps_lfsr10 #(.TAP_MASK(G2_TAP_MASK)) u_g2 (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .q     (g2_q)
    );

    assign bus.code_chip = run & (g1_q[10] ^ g2_q[taps_reg.s1] ^ g2_q[taps_reg.s2]);
    assign bus.chip_idx  = chip_idx_reg;
    assign bus.epoch     = epoch_reg;
    assign bus.bit_edge  = bit_edge_reg;
    assign bus.busy      = run;
    assign bus.prn_err   = prn_err_reg;

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Directed bench for the C/A code generator: known PRN chip prefixes,
// epoch/bit-edge timing over 20 periods, tick detect, PRN errors, reset/stop.
module tb_gps_ca_code_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gps_ca_code_gen_if ifc ();

    gps_ca_code_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One NCO rising edge: tick detected on the first edge, chip advances on the second.
    task automatic advance();
        ifc.nco_msb = 1'b1;
        step();
        ifc.nco_msb = 1'b0;
        step();
    endtask

    task automatic start_prn(input logic [5:0] p);
        ifc.prn_sel = p;
        ifc.start   = 1'b1;
        step();
        ifc.start   = 1'b0;
    endtask

    // Check the first ten chips (MSB of pat = chip 0) and their indices.
    task automatic check_first10(input string tag, input logic [9:0] pat);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s chip%0d", tag, i), 32'(ifc.code_chip), 32'(pat[9-i]));
            check($sformatf("%s idx%0d", tag, i), 32'(ifc.chip_idx), 32'(i));
            advance();
        end
    endtask

    initial begin
        logic [9:0] pat_prn1;
        int ones;
        int ones_bad;
        int epochs;
        int ep_bad;
        int bit_edges;
        int be_at;

        pat_prn1 = 10'o1440;
        rst = 1'b1;
        ifc.nco_msb = 1'b0;
        ifc.start   = 1'b0;
        ifc.stop    = 1'b0;
        ifc.prn_sel = 6'd0;
        repeat (3) step();
        check("rst code_chip", 32'(ifc.code_chip), 0);
        check("rst chip_idx", 32'(ifc.chip_idx), 0);
        check("rst busy", 32'(ifc.busy), 0);
        check("rst epoch", 32'(ifc.epoch), 0);
        check("rst bit_edge", 32'(ifc.bit_edge), 0);
        check("rst prn_err", 32'(ifc.prn_err), 0);
        rst = 1'b0;
        step();

        // PRN 1/2/3 chip prefixes; later starts are in-run restarts.
        start_prn(6'd1);
        check("t1 busy", 32'(ifc.busy), 1);
        check("t1 prn_err", 32'(ifc.prn_err), 0);
        check_first10("t1 prn1", 10'o1440);
        start_prn(6'd2);
        check("t2 restart epoch", 32'(ifc.epoch), 0);
        check_first10("t2 prn2", 10'o1620);
        start_prn(6'd3);
        check_first10("t2 prn3", 10'o1710);

        // 20 full periods of PRN 1.
        start_prn(6'd1);
        ones = 0; ones_bad = 0; epochs = 0; ep_bad = 0; bit_edges = 0; be_at = -1;
        for (int k = 0; k < 20 * 1023; k++) begin
            ones += int'(ifc.code_chip);
            if (k >= 1023 && k < 1033)
                check($sformatf("t3 period2 chip%0d", k - 1023),
                      32'(ifc.code_chip), 32'(pat_prn1[9 - (k - 1023)]));
            advance();
            if ((k % 1023) == 1022) begin
                if (ones != 512) ones_bad++;
                ones = 0;
                if (ifc.epoch !== 1'b1) ep_bad++;
            end else if (ifc.epoch !== 1'b0) begin
                ep_bad++;
            end
            if (ifc.epoch === 1'b1) begin
                epochs++;
                if (ifc.chip_idx !== 10'd0) ep_bad++;
            end
            if (ifc.bit_edge === 1'b1) begin
                bit_edges++;
                be_at = epochs;
                if (ifc.epoch !== 1'b1) ep_bad++;
            end
        end
        check("t3 periods without 512 ones", 32'(ones_bad), 0);
        check("t3 epoch count", 32'(epochs), 20);
        check("t3 misplaced epochs", 32'(ep_bad), 0);
        check("t3 bit_edge count", 32'(bit_edges), 1);
        check("t3 bit_edge at epoch", 32'(be_at), 20);
        check("t3 idx after 20 periods", 32'(ifc.chip_idx), 0);

        // MSB held high for 7 clocks gives one advance, two edges after sampling.
        ifc.nco_msb = 1'b1;
        step();
        check("t4 idx after sample edge", 32'(ifc.chip_idx), 0);
        repeat (6) step();
        ifc.nco_msb = 1'b0;
        step();
        step();
        check("t4 held-high single advance", 32'(ifc.chip_idx), 1);
        ifc.nco_msb = 1'b1;
        step();
        check("t4 toggle latency1", 32'(ifc.chip_idx), 1);
        ifc.nco_msb = 1'b0;
        step();
        check("t4 toggle advance1", 32'(ifc.chip_idx), 2);
        ifc.nco_msb = 1'b1;
        step();
        ifc.nco_msb = 1'b0;
        step();
        check("t4 toggle advance2", 32'(ifc.chip_idx), 3);

        // Invalid PRN in IDLE and in RUN.
        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        check("t5 stop busy", 32'(ifc.busy), 0);
        check("t5 stop idx", 32'(ifc.chip_idx), 0);
        check("t5 stop chip", 32'(ifc.code_chip), 0);
        start_prn(6'd0);
        check("t5 prn0 err", 32'(ifc.prn_err), 1);
        check("t5 prn0 busy", 32'(ifc.busy), 0);
        step();
        check("t5 prn0 err pulse width", 32'(ifc.prn_err), 0);
        start_prn(6'd33);
        check("t5 prn33 err", 32'(ifc.prn_err), 1);
        check("t5 prn33 busy", 32'(ifc.busy), 0);
        start_prn(6'd1);
        repeat (4) advance();
        check("t5 run idx4 chip", 32'(ifc.code_chip), 1);
        start_prn(6'd0);
        check("t5 run err", 32'(ifc.prn_err), 1);
        check("t5 run busy", 32'(ifc.busy), 1);
        check("t5 run idx kept", 32'(ifc.chip_idx), 4);
        check("t5 run chip kept", 32'(ifc.code_chip), 1);
        advance();
        check("t5 run idx5", 32'(ifc.chip_idx), 5);
        check("t5 run err cleared", 32'(ifc.prn_err), 0);
        repeat (2) advance();
        check("t5 run idx7 chip", 32'(ifc.code_chip), 0);

        // Async reset mid-run, then restart; start+stop together stays IDLE.
        start_prn(6'd1);
        repeat (500) advance();
        check("t6 idx before rst", 32'(ifc.chip_idx), 500);
        rst = 1'b1;
        #1;
        check("t6 rst busy", 32'(ifc.busy), 0);
        check("t6 rst idx", 32'(ifc.chip_idx), 0);
        check("t6 rst chip", 32'(ifc.code_chip), 0);
        check("t6 rst epoch", 32'(ifc.epoch), 0);
        #2;
        rst = 1'b0;
        step();
        check("t6 stays idle", 32'(ifc.busy), 0);
        start_prn(6'd1);
        check_first10("t6 prn1 again", 10'o1440);
        ifc.stop = 1'b1;
        start_prn(6'd2);
        ifc.stop = 1'b0;
        check("t6 start+stop busy", 32'(ifc.busy), 0);
        check("t6 start+stop idx", 32'(ifc.chip_idx), 0);
        check("t6 start+stop chip", 32'(ifc.code_chip), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
